// File: rtl/tumble_counter_engine.sv
// Turing Tumble column of N_BITS BIT cells wired as a ripple counter, with blue/red
// dispensers, trays, a lever-return sink and a terminal interceptor. One cell per clock.
module tumble_counter_engine #(
  parameter int                N_BITS      = 4,
  parameter logic [N_BITS-1:0] INIT        = '0,
  parameter int                BLUE_BALLS  = 8,
  parameter int                RED_BALLS   = 8,
  parameter bit                SINK_COLOUR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_BITS-1:0] bits,
  output logic              colour,
  output logic              busy,
  output logic              stopped,
  output logic [1:0]        stop_reason,
  output logic [7:0]        tray_blue,
  output logic [7:0]        tray_red,
  output logic [7:0]        blue_left,
  output logic [7:0]        red_left
);

  localparam int POS_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_BITS - 1);

  localparam logic [1:0] REASON_NONE  = 2'b00;
  localparam logic [1:0] REASON_EMPTY = 2'b01;
  localparam logic [1:0] REASON_CATCH = 2'b10;

  typedef enum logic [1:0] {IDLE, DROP, TRAVEL, HALT} state_t;

  state_t           state;
  logic [POS_W-1:0] pos;
  logic             lever;    // colour of the ball currently being dropped / in flight

  // Balls left in the dispenser that the sink lever feeds.
  logic [7:0] sink_left;
  assign sink_left = SINK_COLOUR ? red_left : blue_left;

  // NOTE: every register here is state, so all updates use <= and only <=; mixing
  // blocking assignments in a clocked block makes results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pos         <= '0;
      lever       <= 1'b0;
      bits        <= INIT;
      colour      <= 1'b0;
      busy        <= 1'b0;
      stopped     <= 1'b0;
      stop_reason <= REASON_NONE;
      tray_blue   <= 8'd0;
      tray_red    <= 8'd0;
      blue_left   <= 8'(BLUE_BALLS);
      red_left    <= 8'(RED_BALLS);
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (blue_left != 8'd0) begin
              state <= DROP;
              lever <= 1'b0;
              busy  <= 1'b1;
            end else begin
              state       <= HALT;
              stopped     <= 1'b1;
              stop_reason <= REASON_EMPTY;
            end
          end
        end

        DROP: begin
          if (lever) begin
            if (red_left != 8'd0) red_left <= red_left - 8'd1;
          end else begin
            if (blue_left != 8'd0) blue_left <= blue_left - 8'd1;
          end
          colour <= lever;
          pos    <= '0;
          state  <= TRAVEL;
        end

        TRAVEL: begin
          bits[pos] <= ~bits[pos];
          if (!bits[pos]) begin
            // Cell flips 0->1 and deflects the ball to the sink.
            if (lever) begin
              if (tray_red != 8'hFF) tray_red <= tray_red + 8'd1;
            end else begin
              if (tray_blue != 8'hFF) tray_blue <= tray_blue + 8'd1;
            end
            if (sink_left != 8'd0) begin
              state <= DROP;
              lever <= SINK_COLOUR;
            end else begin
              state       <= HALT;
              busy        <= 1'b0;
              stopped     <= 1'b1;
              stop_reason <= REASON_EMPTY;
            end
          end else if (pos == LAST_POS) begin
            // Carry out of the top cell: the interceptor swallows the ball.
            state       <= HALT;
            busy        <= 1'b0;
            stopped     <= 1'b1;
            stop_reason <= REASON_CATCH;
          end else begin
            pos <= pos + POS_W'(1);
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tumble_counter_engine.sv
// Bench for tumble_counter_engine: five parameterisations run the puzzle scenarios, and a
// cycle-by-cycle vector table checks flight timing, ignored starts and mid-flight reset.
module tb_tumble_counter_engine;

  typedef struct packed {
    logic [3:0] bits;
    logic       colour;
    logic       busy;
    logic       stopped;
    logic [1:0] reason;
    logic [7:0] tray_blue;
    logic [7:0] tray_red;
    logic [7:0] blue_left;
    logic [7:0] red_left;
  } obs_t;

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] bits;
    logic       busy;
    logic       stopped;
    logic [7:0] blue_left;
    logic [7:0] tray_blue;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0, start_e = 1'b0;
  logic [2:0] a_bits;
  obs_t oa, ob, oc, od, oe;

  int n_vec = 0;
  int n_err = 0;

  vec_t vtab[15];
  vec_t sb[$];

  always #5 clk = ~clk;

  // A: 3-bit counter runs into the interceptor.
  tumble_counter_engine #(.N_BITS(3), .INIT(3'b000), .BLUE_BALLS(8)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .bits(a_bits), .colour(oa.colour),
    .busy(oa.busy), .stopped(oa.stopped), .stop_reason(oa.reason),
    .tray_blue(oa.tray_blue), .tray_red(oa.tray_red),
    .blue_left(oa.blue_left), .red_left(oa.red_left));
  assign oa.bits = {1'b0, a_bits};

  // B: blue dispenser runs dry.
  tumble_counter_engine #(.N_BITS(4), .BLUE_BALLS(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .bits(ob.bits), .colour(ob.colour),
    .busy(ob.busy), .stopped(ob.stopped), .stop_reason(ob.reason),
    .tray_blue(ob.tray_blue), .tray_red(ob.tray_red),
    .blue_left(ob.blue_left), .red_left(ob.red_left));

  // C: sink returns to the red lever.
  tumble_counter_engine #(.N_BITS(4), .SINK_COLOUR(1'b1), .BLUE_BALLS(1), .RED_BALLS(3)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .bits(oc.bits), .colour(oc.colour),
    .busy(oc.busy), .stopped(oc.stopped), .stop_reason(oc.reason),
    .tray_blue(oc.tray_blue), .tray_red(oc.tray_red),
    .blue_left(oc.blue_left), .red_left(oc.red_left));

  // D: timing from a non-zero initial pattern.
  tumble_counter_engine #(.N_BITS(4), .INIT(4'b0011)) u_d (
    .clk(clk), .rst(rst), .start(start_d), .bits(od.bits), .colour(od.colour),
    .busy(od.busy), .stopped(od.stopped), .stop_reason(od.reason),
    .tray_blue(od.tray_blue), .tray_red(od.tray_red),
    .blue_left(od.blue_left), .red_left(od.red_left));

  // E: empty blue dispenser from reset.
  tumble_counter_engine #(.N_BITS(4), .INIT(4'b0101), .BLUE_BALLS(0)) u_e (
    .clk(clk), .rst(rst), .start(start_e), .bits(oe.bits), .colour(oe.colour),
    .busy(oe.busy), .stopped(oe.stopped), .stop_reason(oe.reason),
    .tray_blue(oe.tray_blue), .tray_red(oe.tray_red),
    .blue_left(oe.blue_left), .red_left(oe.red_left));

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_starts(input logic v);
    start_a = v; start_b = v; start_c = v; start_e = v;
  endtask

  task automatic fill_table();
    //            rst   start bits     busy  stop  bl    tb
    vtab[0]  = '{1'b1, 1'b0, 4'b0011, 1'b0, 1'b0, 8'd8, 8'd0};
    vtab[1]  = '{1'b0, 1'b1, 4'b0011, 1'b1, 1'b0, 8'd8, 8'd0}; // DROP
    vtab[2]  = '{1'b0, 1'b0, 4'b0011, 1'b1, 1'b0, 8'd7, 8'd0}; // TRAVEL cell0
    vtab[3]  = '{1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 8'd7, 8'd0}; // TRAVEL cell1
    vtab[4]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 8'd7, 8'd0}; // TRAVEL cell2
    vtab[5]  = '{1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 8'd7, 8'd1}; // sink -> DROP
    vtab[6]  = '{1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 8'd6, 8'd1}; // start ignored
    vtab[7]  = '{1'b0, 1'b0, 4'b0101, 1'b1, 1'b0, 8'd6, 8'd2}; // sink -> DROP
    vtab[8]  = '{1'b0, 1'b0, 4'b0101, 1'b1, 1'b0, 8'd5, 8'd2}; // third ball TRAVEL
    vtab[9]  = '{1'b1, 1'b0, 4'b0011, 1'b0, 1'b0, 8'd8, 8'd0}; // reset mid-flight
    vtab[10] = '{1'b0, 1'b1, 4'b0011, 1'b1, 1'b0, 8'd8, 8'd0};
    vtab[11] = '{1'b0, 1'b0, 4'b0011, 1'b1, 1'b0, 8'd7, 8'd0};
    vtab[12] = '{1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 8'd7, 8'd0};
    vtab[13] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 8'd7, 8'd0};
    vtab[14] = '{1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 8'd7, 8'd1};
  endtask

  initial begin
    vec_t exp_v;
    int   cycles;

    fill_table();

    // Reset state.
    step();
    check("d_reset_bits", od.bits, 4'b0011);
    check("d_reset_busy", od.busy, 0);
    check("d_reset_stopped", od.stopped, 0);
    check("d_reset_reason", od.reason, 0);
    check("c_reset_red_left", oc.red_left, 3);
    check("a_reset_blue_left", oa.blue_left, 8);
    rst = 1'b0;

    // Puzzle runs on A, B, C, E in parallel.
    set_starts(1'b1);
    step();
    set_starts(1'b0);
    check("e_stopped", oe.stopped, 1);
    check("e_reason", oe.reason, 1);
    check("e_bits", oe.bits, 4'b0101);
    check("e_busy", oe.busy, 0);
    check("a_busy_after_start", oa.busy, 1);

    cycles = 0;
    while (!(oa.stopped && ob.stopped && oc.stopped) && cycles < 200) begin
      step();
      cycles++;
    end
    check("run_within_budget", int'(cycles < 200), 1);

    check("a_bits", oa.bits, 0);
    check("a_reason", oa.reason, 2);
    check("a_tray_blue", oa.tray_blue, 7);
    check("a_blue_left", oa.blue_left, 0);
    check("a_busy", oa.busy, 0);
    check("b_bits", ob.bits, 4'b0010);
    check("b_tray_blue", ob.tray_blue, 2);
    check("b_reason", ob.reason, 1);
    check("b_stopped", ob.stopped, 1);
    check("c_bits", oc.bits, 4'b0100);
    check("c_colour", oc.colour, 1);
    check("c_tray_blue", oc.tray_blue, 1);
    check("c_tray_red", oc.tray_red, 3);
    check("c_red_left", oc.red_left, 0);
    check("c_reason", oc.reason, 1);

    // Start in HALT is ignored.
    set_starts(1'b1);
    step();
    set_starts(1'b0);
    repeat (3) step();
    check("a_halt_bits", oa.bits, 0);
    check("a_halt_tray", oa.tray_blue, 7);
    check("b_halt_bits", ob.bits, 4'b0010);
    check("c_halt_tray_red", oc.tray_red, 3);
    check("e_halt_bits", oe.bits, 4'b0101);
    check("e_halt_reason", oe.reason, 1);

    // Cycle-exact vectors on D through the scoreboard.
    for (int i = 0; i < 15; i++) begin
      rst     = vtab[i].rst;
      start_d = vtab[i].start;
      sb.push_back(vtab[i]);
      step();
      exp_v = sb.pop_front();
      check($sformatf("v%0d_bits", i), od.bits, exp_v.bits);
      check($sformatf("v%0d_busy", i), od.busy, exp_v.busy);
      check($sformatf("v%0d_stopped", i), od.stopped, exp_v.stopped);
      check($sformatf("v%0d_blue_left", i), od.blue_left, exp_v.blue_left);
      check($sformatf("v%0d_tray_blue", i), od.tray_blue, exp_v.tray_blue);
    end
    rst     = 1'b0;
    start_d = 1'b0;

    // Reset on the parallel instances cleared their halt.
    check("a_post_reset_stopped", oa.stopped, 0);
    check("c_post_reset_tray_red", oc.tray_red, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tumble_counter_engine.md
Name: tumble_counter_engine

Overview:
- Clocked, parametrised successor to the combinational two-bit puzzle boards.
- Models a Turing Tumble column of N_BITS BIT cells wired as a ripple counter.
- Includes blue and red ball dispensers, trays, a lever-return sink and a terminal interceptor.
- Balls travel one BIT cell per clock. The block exposes the bit states, the current ball colour, tray counts and the stop condition, for puzzle solutions and regression benches.

Parameters:
- N_BITS, 4: number of chained BIT cells (1..16).
- INIT, 0: initial BIT states; bit k is cell k; cell 0 is hit first.
- BLUE_BALLS, 8: blue dispenser capacity at reset (0..255).
- RED_BALLS, 8: red dispenser capacity at reset (0..255).
- SINK_COLOUR, 0: lever pulled when a ball exits to the sink (0 = blue, 1 = red).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; pulls the blue lever; honoured only in IDLE.
- bits  out  N_BITS  current BIT cell states.
- colour  out  1  colour of the last released ball (0 = blue, 1 = red).
- busy  out  1  a ball is in flight (state DROP or TRAVEL).
- stopped  out  1  machine halted.
- stop_reason  out  2  00 none, 01 dispenser empty, 10 interceptor.
- tray_blue  out  8  blue balls collected in the tray.
- tray_red  out  8  red balls collected in the tray.
- blue_left  out  8  blue balls remaining in the dispenser.
- red_left  out  8  red balls remaining in the dispenser.

Behaviour:
- Reset (sync, has priority over everything, including mid-flight):
  - bits = INIT; colour = 0; busy = 0; stopped = 0; stop_reason = 00.
  - tray_blue = tray_red = 0; blue_left = BLUE_BALLS; red_left = RED_BALLS.
  - state = IDLE; in-flight ball discarded; pos = 0.
- States: IDLE, DROP, TRAVEL, HALT.
- IDLE:
  - start = 1 and blue_left > 0: go to DROP with lever = blue.
  - start = 1 and blue_left = 0: go to HALT with stop_reason = 01.
  - start = 0: stay in IDLE.
- DROP (exactly 1 cycle):
  - Decrement the selected dispenser's remaining count.
  - colour = lever colour; pos = 0; next state TRAVEL.
- TRAVEL (1 cycle per cell visited; cell[pos] toggles every cycle):
  - Cell was 0 (becomes 1): ball exits to the sink and the lever colour's tray count increments.
    - If the SINK_COLOUR dispenser still has balls, go to DROP with lever = SINK_COLOUR.
    - Otherwise go to HALT with stop_reason = 01.
  - Cell was 1 (becomes 0), pos < N_BITS-1: pos + 1 and stay in TRAVEL.
  - Cell was 1 (becomes 0), pos = N_BITS-1: ball is caught by the interceptor and is not added to a tray; go to HALT with stop_reason = 10.
- HALT:
  - stopped = 1 and all state is frozen.
  - start is ignored; only rst leaves HALT.
- Counting and timing:
  - Each ball adds 1 to bits, treated as an unsigned value with cell 0 as the LSB.
  - A ball's flight takes 1 + (trailing ones of bits + 1) cycles, capped at N_BITS visits.
- Boundary rules:
  - start in DROP, TRAVEL or HALT is ignored and is not queued.
  - Tray counts saturate at 255; dispenser counts never underflow.
  - BLUE_BALLS = 0: the first start halts with reason 01 in the next cycle; bits are unchanged.
  - Empty-dispenser check happens on the lever pull. A ball already in flight always completes.
- Outputs are registered, with no combinational path from start to any output.

Test Plan:
- N_BITS=3, INIT=0, BLUE_BALLS=8, start at cycle 0 -> bits steps 001, 010, …, 111 after 7 balls. The 8th ball clears to 000 and hits the interceptor. Expect stopped = 1, stop_reason = 10, tray_blue = 7, blue_left = 0.
- N_BITS=4, BLUE_BALLS=2 -> after 2 balls bits = 0010 and tray_blue = 2. The next lever pull finds the dispenser empty: stop_reason = 01, stopped = 1.
- SINK_COLOUR=1, BLUE_BALLS=1, RED_BALLS=3, N_BITS=4 -> bits = 0100, colour = 1, tray_blue = 1, tray_red = 3, red_left = 0, stop_reason = 01.
- Timing check, N_BITS=4, INIT=4'b0011 -> start at cycle 0; DROP at cycle 1; TRAVEL at cycles 2–4. At cycle 5 expect bits = 0100 and state DROP.
- rst asserted mid-TRAVEL of the third ball -> next cycle bits = INIT, trays = 0, dispensers full, busy = 0; a new start runs normally.
- start pulsed while busy and while in HALT -> no extra ball is released and no counter changes.
